// File: rtl/vram_writer.sv
// Host write port into text-mode VRAM: buffers host register writes in a small
// FIFO and commits them (or a clear-screen fill) only during sampled write slots.
module vram_writer #(
  parameter int unsigned ADDR_W     = 13,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned VRAM_WORDS = 2400,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [1:0]        host_reg,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_wa,
  output logic [DATA_W-1:0] vram_wd,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_WORDS - 1);
  localparam logic [ADDR_W-1:0] WORDS     = ADDR_W'(VRAM_WORDS);

  localparam logic [1:0] REG_ADDR   = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CURSOR = 2'd2;

  typedef enum logic [1:0] {IDLE, DRAIN, FILL} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [ADDR_W-1:0] fill_ptr, fill_ptr_next;
  logic [DATA_W-1:0] fill_val, fill_val_next;
  logic [ADDR_W-1:0] cursor_next;
  logic              we_next;
  logic [ADDR_W-1:0] wa_next;
  logic [DATA_W-1:0] wd_next;
  logic              busy_next;

  logic [ENT_W-1:0]  mem [FIFO_DEPTH];
  logic [CNT_W-1:0]  wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic              fifo_empty, fifo_full;
  logic              push, pop, accept;
  logic [ENT_W-1:0]  fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = mem[rd_ptr[PTR_W-1:0]];

  // Ready looks only at start-of-cycle state, so a pop never frees a slot early
  assign host_ready = !rst && (state == IDLE) && !fifo_full;
  assign accept     = host_valid && host_ready;

  // Next-state, FIFO control and commit selection
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    fill_ptr_next = fill_ptr;
    fill_val_next = fill_val;
    cursor_next   = cursor_addr;
    we_next       = 1'b0;
    wa_next       = vram_wa;
    wd_next       = vram_wd;
    push          = 1'b0;
    pop           = 1'b0;

    if (accept) begin
      case (host_reg)
        REG_ADDR:   ptr_next = (host_wdata[ADDR_W-1:0] >= WORDS) ? '0 : host_wdata[ADDR_W-1:0];
        REG_DATA: begin
          push     = 1'b1;
          ptr_next = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
        end
        REG_CURSOR: cursor_next = host_wdata[ADDR_W-1:0];
        default: begin
          fill_val_next = host_wdata;
          state_next    = DRAIN;
        end
      endcase
    end

    case (state)
      IDLE, DRAIN: begin
        if (slot && !fifo_empty) begin
          pop                = 1'b1;
          we_next            = 1'b1;
          {wa_next, wd_next} = fifo_head;
        end
        if (state == DRAIN && fifo_empty) begin
          state_next    = FILL;
          fill_ptr_next = '0;
        end
      end
      FILL: begin
        if (slot) begin
          we_next = 1'b1;
          wa_next = fill_ptr;
          wd_next = fill_val;
          if (fill_ptr == LAST_ADDR) begin
            fill_ptr_next = '0;
            ptr_next      = '0;
            state_next    = IDLE;
          end else begin
            fill_ptr_next = fill_ptr + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    wr_ptr_next = wr_ptr + CNT_W'(push);
    rd_ptr_next = rd_ptr + CNT_W'(pop);
    busy_next   = (state_next != IDLE) || (wr_ptr_next != rd_ptr_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      fill_ptr    <= '0;
      fill_val    <= '0;
      cursor_addr <= '0;
      vram_we     <= 1'b0;
      vram_wa     <= '0;
      vram_wd     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      fill_ptr    <= fill_ptr_next;
      fill_val    <= fill_val_next;
      cursor_addr <= cursor_next;
      vram_we     <= we_next;
      vram_wa     <= wa_next;
      vram_wd     <= wd_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      busy        <= busy_next;
    end
  end

  // Storage needs no reset; occupancy lives in the pointers
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {ptr, host_wdata};
  end

endmodule

// File: tb/tb_vram_writer.sv
// Directed bench for vram_writer: per-cycle vector table plus hand-written
// sequences for FIFO-full backpressure, screen fill and reset mid-fill.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slot = 1'b0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [1:0]  host_reg = 2'd0;
  logic [15:0] host_wdata = 16'd0;
  logic        vram_we;
  logic [12:0] vram_wa;
  logic [15:0] vram_wd;
  logic [12:0] cursor_addr;
  logic        busy;

  vram_writer dut (
    .clk(clk), .rst(rst), .slot(slot),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_reg(host_reg), .host_wdata(host_wdata),
    .vram_we(vram_we), .vram_wa(vram_wa), .vram_wd(vram_wd),
    .cursor_addr(cursor_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, valid; logic [1:0] r; logic [15:0] d; logic slot;
    logic e_we; logic [12:0] e_wa; logic [15:0] e_wd; logic [12:0] e_cur;
    logic e_busy, e_ready;
  } vec_t;

  typedef struct { logic [12:0] a; logic [15:0] d; } wr_t;

  int   n_vec = 0;
  int   n_err = 0;
  wr_t  wq[$];
  vec_t vt[20];

  always @(negedge clk) begin
    wr_t w;
    if (vram_we === 1'b1) begin
      w.a = vram_wa; w.d = vram_wd;
      wq.push_back(w);
    end
  end

  function automatic vec_t mk(input logic r_, v, input logic [1:0] rg, input logic [15:0] d,
                              input logic s, input logic we, input logic [12:0] wa,
                              input logic [15:0] wd, input logic [12:0] cur,
                              input logic b, input logic rdy);
    vec_t x;
    x.rst = r_; x.valid = v; x.r = rg; x.d = d; x.slot = s;
    x.e_we = we; x.e_wa = wa; x.e_wd = wd; x.e_cur = cur; x.e_busy = b; x.e_ready = rdy;
    return x;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] r, input logic [15:0] d, input logic s);
    host_valid = v; host_reg = r; host_wdata = d; slot = s;
    @(posedge clk); #1;
  endtask

  logic [15:0] w [6];
  int          bad;
  logic        got;

  initial begin
    // rst v  reg   data      slot | we wa    wd        cur      busy rdy
    vt[0]  = mk(1, 0, 2'd0, 16'h0000, 0, 0, 13'd0,    16'h0000, 13'h000, 0, 0);
    vt[1]  = mk(0, 1, 2'd0, 16'd100,  0, 0, 13'd0,    16'h0000, 13'h000, 0, 1);
    vt[2]  = mk(0, 1, 2'd1, 16'h1F41, 0, 0, 13'd0,    16'h0000, 13'h000, 1, 1);
    vt[3]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, 13'd0,    16'h0000, 13'h000, 1, 1);
    vt[4]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, 13'd0,    16'h0000, 13'h000, 1, 1);
    vt[5]  = mk(0, 0, 2'd0, 16'h0000, 1, 1, 13'd100,  16'h1F41, 13'h000, 0, 1);
    vt[6]  = mk(0, 0, 2'd0, 16'h0000, 0, 0, 13'd100,  16'h1F41, 13'h000, 0, 1);
    vt[7]  = mk(0, 0, 2'd0, 16'h0000, 1, 0, 13'd100,  16'h1F41, 13'h000, 0, 1);
    vt[8]  = mk(0, 1, 2'd2, 16'h0123, 0, 0, 13'd100,  16'h1F41, 13'h123, 0, 1);
    vt[9]  = mk(0, 1, 2'd0, 16'd5000, 0, 0, 13'd100,  16'h1F41, 13'h123, 0, 1);
    vt[10] = mk(0, 1, 2'd1, 16'h5555, 0, 0, 13'd100,  16'h1F41, 13'h123, 1, 1);
    vt[11] = mk(0, 0, 2'd0, 16'h0000, 1, 1, 13'd0,    16'h5555, 13'h123, 0, 1);
    vt[12] = mk(0, 1, 2'd0, 16'd2399, 0, 0, 13'd0,    16'h5555, 13'h123, 0, 1);
    vt[13] = mk(0, 1, 2'd1, 16'hAAAA, 0, 0, 13'd0,    16'h5555, 13'h123, 1, 1);
    vt[14] = mk(0, 1, 2'd1, 16'hBBBB, 1, 1, 13'd2399, 16'hAAAA, 13'h123, 1, 1);
    vt[15] = mk(0, 0, 2'd0, 16'h0000, 0, 0, 13'd2399, 16'hAAAA, 13'h123, 1, 1);
    vt[16] = mk(0, 0, 2'd0, 16'h0000, 1, 1, 13'd0,    16'hBBBB, 13'h123, 0, 1);
    vt[17] = mk(0, 1, 2'd0, 16'd2400, 0, 0, 13'd0,    16'hBBBB, 13'h123, 0, 1);
    vt[18] = mk(0, 1, 2'd1, 16'h1234, 0, 0, 13'd0,    16'hBBBB, 13'h123, 1, 1);
    vt[19] = mk(0, 0, 2'd0, 16'h0000, 1, 1, 13'd0,    16'h1234, 13'h123, 0, 1);

    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst;
      drive(vt[i].valid, vt[i].r, vt[i].d, vt[i].slot);
      check($sformatf("v%0d_we", i),    32'(vram_we),     32'(vt[i].e_we));
      check($sformatf("v%0d_wa", i),    32'(vram_wa),     32'(vt[i].e_wa));
      check($sformatf("v%0d_wd", i),    32'(vram_wd),     32'(vt[i].e_wd));
      check($sformatf("v%0d_cur", i),   32'(cursor_addr), 32'(vt[i].e_cur));
      check($sformatf("v%0d_busy", i),  32'(busy),        32'(vt[i].e_busy));
      check($sformatf("v%0d_ready", i), 32'(host_ready),  32'(vt[i].e_ready));
    end

    // FIFO full backpressure and refusal during the full+pop cycle
    w[0] = 16'hC000; w[1] = 16'hC001; w[2] = 16'hC002;
    w[3] = 16'hC003; w[4] = 16'hC004; w[5] = 16'hC005;
    drive(1, 2'd0, 16'd10, 0);
    wq.delete();
    for (int k = 0; k < 4; k++) begin
      host_reg = 2'd1; host_wdata = w[k];
      check($sformatf("full_acc%0d_ready", k), 32'(host_ready), 32'd1);
      @(posedge clk); #1;
    end
    host_wdata = w[4];
    check("full_ready", 32'(host_ready), 32'd0);
    slot = 1'b1;
    @(posedge clk); #1;
    slot = 1'b0;
    check("full_pop_we", 32'(vram_we), 32'd1);
    check("full_pop_wa", 32'(vram_wa), 32'd10);
    check("full_pop_wd", 32'(vram_wd), 32'(w[0]));
    check("full_ready_back", 32'(host_ready), 32'd1);
    @(posedge clk); #1;
    check("full_again_ready", 32'(host_ready), 32'd0);
    host_wdata = w[5]; slot = 1'b1; got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (host_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    host_valid = 1'b0;
    check("full_w5_accepted", 32'(got), 32'd1);
    repeat (8) begin @(posedge clk); #1; end
    slot = 1'b0;
    check("full_write_count", wq.size(), 6);
    bad = 0;
    if (wq.size() == 6)
      for (int i = 0; i < 6; i++)
        if (wq[i].a != 13'(10 + i) || wq[i].d != w[i]) bad++;
    check("full_write_order", bad, 0);
    check("full_busy_done", 32'(busy), 32'd0);

    // Two pending writes, then a full-screen fill with a slot every cycle
    drive(1, 2'd0, 16'd7, 0);
    drive(1, 2'd1, 16'h1111, 0);
    drive(1, 2'd1, 16'h2222, 0);
    wq.delete();
    drive(1, 2'd3, 16'h0720, 0);
    host_valid = 1'b0; slot = 1'b1;
    bad = 0; got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (!busy) got = 1'b1;
      else if (host_ready) bad++;
      if (!got) begin @(posedge clk); #1; end
    end
    check("fill_finished", 32'(got), 32'd1);
    check("fill_ready_low", bad, 0);
    check("fill_idle_ready", 32'(host_ready), 32'd1);
    @(posedge clk); #1;
    check("fill_write_count", wq.size(), 2402);
    if (wq.size() >= 2) begin
      check("fill_pre0_addr", 32'(wq[0].a), 32'd7);
      check("fill_pre0_data", 32'(wq[0].d), 32'h1111);
      check("fill_pre1_addr", 32'(wq[1].a), 32'd8);
      check("fill_pre1_data", 32'(wq[1].d), 32'h2222);
    end
    bad = 0;
    if (wq.size() == 2402)
      for (int i = 0; i < 2400; i++)
        if (wq[i + 2].a != 13'(i) || wq[i + 2].d != 16'h0720) bad++;
    check("fill_words", bad, 0);
    wq.delete();
    drive(1, 2'd1, 16'h3333, 1);
    host_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("post_fill_count", wq.size(), 1);
    if (wq.size() == 1) begin
      check("post_fill_addr", 32'(wq[0].a), 32'd0);
      check("post_fill_data", 32'(wq[0].d), 32'h3333);
    end

    // Reset in the middle of a fill
    drive(1, 2'd3, 16'h00FF, 1);
    host_valid = 1'b0; got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (vram_we && vram_wa == 13'd1000) got = 1'b1;
    end
    check("rst_reached_1000", 32'(got), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_we",    32'(vram_we),     32'd0);
    check("rst_wa",    32'(vram_wa),     32'd0);
    check("rst_wd",    32'(vram_wd),     32'd0);
    check("rst_cur",   32'(cursor_addr), 32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_ready", 32'(host_ready),  32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(host_ready), 32'd1);
    wq.delete();
    repeat (20) begin @(posedge clk); #1; end
    check("rst_no_writes", wq.size(), 0);
    check("rst_idle_busy", 32'(busy), 32'd0);
    drive(1, 2'd1, 16'h4444, 1);
    host_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    slot = 1'b0;
    check("rst_data_count", wq.size(), 1);
    if (wq.size() == 1) begin
      check("rst_data_addr", 32'(wq[0].a), 32'd0);
      check("rst_data_data", 32'(wq[0].d), 32'h4444);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
